alu_mul_seq: RTL and testbench
==============================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request a multiply; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1, cancel an in-progress multiply.
REQ-005 SHALL have ports mcand and mplier, input, 32 each, unsigned multiplicand and multiplier, captured on start acceptance.
REQ-006 SHALL have port busy, output, 1, high in RUN.
REQ-007 SHALL have port result_valid, output, 1, high in DONE.
REQ-008 SHALL have port result_ack, input, 1, consumer accepts the result.
REQ-009 SHALL have port result, output, 64, product {acc,q}.
REQ-010 SHALL have port alu_a, output, 32, driven from the acc register.
REQ-011 SHALL have port alu_b, output, 32, driven from the mcand register.
REQ-012 SHALL have ports alu_s (output, 4), alu_m (output, 1) and alu_cin_n (output, 1), the function select to the external 32-bit 74S181-slice ALU, active-high data convention.
REQ-013 SHALL have ports alu_f (input, 32) and alu_cout_n (input, 1), the combinational ALU result and active-low carry-out, valid in the same cycle.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL load mcand, set q=mplier, acc=0 and count=0, and enter RUN on the next edge.
REQ-016 In RUN with q[0]=1, the block SHALL drive ADD: alu_s=1001, alu_m=0, alu_cin_n=1 (F=A plus B).
REQ-017 In RUN with q[0]=0, the block SHALL drive PASS-A: alu_s=1111, alu_m=1, alu_cin_n=1 (F=A); carry SHALL be taken as 0 regardless of alu_cout_n.
REQ-018 Each RUN edge SHALL update {acc,q} to {carry, alu_f, q[31:1]}, where carry = ~alu_cout_n for ADD, and SHALL increment the 5-bit count.
REQ-019 The RUN edge with count=31 SHALL perform the final step and enter DONE; latency is exactly 32 RUN cycles, with result_valid first high 33 edges after start acceptance.
REQ-020 In IDLE and DONE, the ALU controls SHALL hold the PASS-A encoding.
REQ-021 DONE SHALL hold result and result_valid stable until result_ack=1, then enter IDLE on that edge.
REQ-022 start SHALL be ignored outside IDLE; result_ack SHALL be ignored outside DONE.
REQ-023 abort=1 in RUN SHALL enter IDLE on the next edge with busy=0 and result_valid=0; abort has priority over the count=31 completion.
REQ-024 abort SHALL be ignored in IDLE and DONE.
REQ-025 start and result_ack in the same DONE cycle SHALL only complete the ack; the new start requires a later IDLE cycle.
REQ-026 result SHALL equal mcand*mplier exactly for all 32-bit operands, with no overflow.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE and clear acc, q, mcand and count.
REQ-028 During reset, busy=0, result_valid=0, result=0, and the ALU controls SHALL hold PASS-A.
REQ-029 Reset asserted mid-RUN SHALL discard the operation; after release, the block SHALL accept a new start normally.

Structure
REQ-030 A shared package SHALL hold the state enum and the ALU op constants (ADD and PASS-A S/M/CIN_N encodings).
REQ-031 Datapath, counter and FSM SHALL reside in alu_mul_seq.
REQ-032 The ALU SHALL be external: eight 4-bit slices with ripple carry, instantiated by the integrating level and the bench.

Verification
REQ-033 mcand=3, mplier=5, start -> result_valid after 33 edges, result=0x0000_0000_0000_000F.
REQ-034 mcand=mplier=0xFFFFFFFF -> result=0xFFFFFFFE_00000001; carry path exercised on every step.
REQ-035 mcand=0x80000000, mplier=2 -> result=0x00000001_00000000; mplier=0 -> result=0, with PASS-A driven on every step.
REQ-036 abort at RUN cycle 10, then at count=31 -> IDLE next edge, no result_valid; new start then completes correctly.
REQ-037 reset_n low at RUN cycle 20 -> outputs cleared asynchronously; start ignored mid-RUN; result held across 5 idle cycles until result_ack.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_mul_seq_pkg
// Desc   : Shared state encoding and 74S181 function-select constants.
// Rev    : 1.0 - initial release
// ============================================================================
package alu_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          c_DATA_W         = 32;
  localparam logic [4:0]  c_COUNT_LAST     = 5'd31;

  // F = A plus B, no carry in (active-high data convention)
  localparam logic [3:0]  c_ALU_ADD_S      = 4'b1001;
  localparam logic        c_ALU_ADD_M      = 1'b0;
  localparam logic        c_ALU_ADD_CIN_N  = 1'b1;

  // F = A, logic mode
  localparam logic [3:0]  c_ALU_PASS_S     = 4'b1111;
  localparam logic        c_ALU_PASS_M     = 1'b1;
  localparam logic        c_ALU_PASS_CIN_N = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_mul_seq
// Desc   : 32x32 unsigned shift-add multiplier sequencing an external
//          32-bit 74S181 ALU; one add-or-pass step per cycle, 32 steps.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [c_DATA_W-1:0]   mcand,
  input  logic [c_DATA_W-1:0]   mplier,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic [2*c_DATA_W-1:0] result,
  output logic [c_DATA_W-1:0]   alu_a,
  output logic [c_DATA_W-1:0]   alu_b,
  output logic [3:0]            alu_s,
  output logic                  alu_m,
  output logic                  alu_cin_n,
  input  logic [c_DATA_W-1:0]   alu_f,
  input  logic                  alu_cout_n
);

  state_t              r_state;
  logic [c_DATA_W-1:0] r_acc;
  logic [c_DATA_W-1:0] r_q;
  logic [c_DATA_W-1:0] r_mcand;
  logic [4:0]          r_count;
  logic                r_busy;
  logic                r_result_valid;

  logic                w_add;
  logic                w_carry;

  // Only a RUN step with the current multiplier LSB set adds; everything
  // else (including IDLE/DONE) keeps the ALU in pass-A.
  assign w_add     = (r_state == ST_RUN) && r_q[0];
  assign w_carry   = w_add & ~alu_cout_n;

  assign alu_s     = w_add ? c_ALU_ADD_S     : c_ALU_PASS_S;
  assign alu_m     = w_add ? c_ALU_ADD_M     : c_ALU_PASS_M;
  assign alu_cin_n = w_add ? c_ALU_ADD_CIN_N : c_ALU_PASS_CIN_N;

  assign alu_a        = r_acc;
  assign alu_b        = r_mcand;
  assign result       = {r_acc, r_q};
  assign busy         = r_busy;
  assign result_valid = r_result_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_q            <= '0;
      r_mcand        <= '0;
      r_count        <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= mcand;
            r_q     <= mplier;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // abort wins even over the final step
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            {r_acc, r_q} <= {w_carry, alu_f, r_q[c_DATA_W-1:1]};
            r_count      <= r_count + 5'd1;
            if (r_count == c_COUNT_LAST) begin
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
              r_state        <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (result_ack) begin
            r_result_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end

        default: begin
          r_busy         <= 1'b0;
          r_result_valid <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_mul_seq
// Desc   : Bench for alu_mul_seq with an eight-slice 74S181 ripple ALU model
//          and an arithmetic reference model of the multiply protocol.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        start      = 1'b0;
  logic        abort      = 1'b0;
  logic        result_ack = 1'b0;
  logic [31:0] mcand      = '0;
  logic [31:0] mplier     = '0;
  logic        busy;
  logic        result_valid;
  logic [63:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_f;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic        alu_cin_n;
  logic        alu_cout_n;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .mcand        (mcand),
    .mplier       (mplier),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .result       (result),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_s        (alu_s),
    .alu_m        (alu_m),
    .alu_cin_n    (alu_cin_n),
    .alu_f        (alu_f),
    .alu_cout_n   (alu_cout_n)
  );

  // One 74S181 slice: only the two functions the multiplier uses are modelled.
  // Logic mode reports an active carry so a design that wrongly uses it shows up.
  function automatic logic [4:0] s181(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] s, input logic m,
                                      input logic cin_n);
    logic [4:0] sum;
    if (m && s == 4'b1111) return {1'b0, a};
    if (!m && s == 4'b1001) begin
      sum = {1'b0, a} + {1'b0, b} + {4'b0, ~cin_n};
      return {~sum[4], sum[3:0]};
    end
    return {1'b0, a ^ 4'hA};
  endfunction

  always_comb begin
    logic       c_n;
    logic [4:0] r;
    alu_f = '0;
    c_n   = alu_cin_n;
    r     = '0;
    for (int i = 0; i < 8; i++) begin
      r              = s181(alu_a[4*i +: 4], alu_b[4*i +: 4], alu_s, alu_m, c_n);
      alu_f[4*i +: 4] = r[3:0];
      c_n            = r[4];
    end
    alu_cout_n = c_n;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: after k steps the 64-bit register pair holds the partial
  // product of the low k multiplier bits above the still-unused multiplier bits.
  function automatic logic [63:0] partial(input logic [63:0] a, input logic [63:0] b,
                                          input int k);
    logic [63:0] low;
    low = b & ((64'd1 << k) - 64'd1);
    return ((a * low) << (32 - k)) | (b >> k);
  endfunction

  int          m_phase = 0;   // 0 idle, 1 multiplying, 2 result held
  int          m_k     = 0;
  logic [63:0] m_a     = '0;
  logic [63:0] m_b     = '0;
  bit          m_clean = 1'b1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_k = 0; m_a = '0; m_b = '0; m_clean = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_a = {32'b0, mcand}; m_b = {32'b0, mplier};
          m_k = 0; m_phase = 1; m_clean = 1'b0;
        end
        1: if (abort) m_phase = 0;
           else begin
             m_k++;
             if (m_k == 32) m_phase = 2;
           end
        default: if (result_ack) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    logic [5:0]  op;
    chk("busy", {63'b0, busy}, {63'b0, m_phase == 1});
    chk("result_valid", {63'b0, result_valid}, {63'b0, m_phase == 2});
    op = (m_phase == 1 && m_b[m_k]) ? 6'b1001_0_1 : 6'b1111_1_1;
    chk("alu_op", {58'b0, alu_s, alu_m, alu_cin_n}, {58'b0, op});
    if (m_phase != 0) begin
      e = partial(m_a, m_b, m_k);
      chk("result", result, e);
    end else if (m_clean) begin
      chk("result_reset", result, 64'd0);
    end
    if (m_phase == 1) begin
      chk("alu_a", {32'b0, alu_a}, {32'b0, e[63:32]});
      chk("alu_b", {32'b0, alu_b}, m_a);
    end
  end

  // poke: stray start/ack while running, abort while done, start with the ack
  task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                     input int hold, input bit poke, input bit abort_at_start,
                     input string name);
    int edges;
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1; abort = abort_at_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; edges = 1;
    while (!result_valid && edges < 40) begin
      if (poke && edges == 10) begin
        start = 1'b1; result_ack = 1'b1; mcand = ~a; mplier = ~b;
      end
      if (poke && edges == 11) begin
        start = 1'b0; result_ack = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    chk({name, " latency"}, 64'(edges), 64'd33);
    chk({name, " product"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      abort = poke && (i == 0);
      @(negedge clk);
    end
    abort = 1'b0;
    chk({name, " held valid"}, {63'b0, result_valid}, 64'd1);
    chk({name, " held product"}, result, exp);
    result_ack = 1'b1; start = poke;
    @(negedge clk);
    result_ack = 1'b0; start = 1'b0;
    chk({name, " valid after ack"}, {63'b0, result_valid}, 64'd0);
    @(negedge clk);
    chk({name, " no start on ack"}, {63'b0, busy}, 64'd0);
  endtask

  task automatic abort_at(input int at, input string name);
    int edges;
    @(negedge clk);
    mcand = 32'h0000_0011; mplier = 32'h0000_00FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; edges = 1;
    while (edges < at) begin @(negedge clk); edges++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk({name, " busy"}, {63'b0, busy}, 64'd0);
    chk({name, " valid"}, {63'b0, result_valid}, 64'd0);
    repeat (3) @(negedge clk);
    chk({name, " no late valid"}, {63'b0, result_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int edges;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset valid", {63'b0, result_valid}, 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset alu op", {58'b0, alu_s, alu_m, alu_cin_n}, 64'b111111);
    reset_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort in idle", {63'b0, busy}, 64'd0);

    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, 1'b0, "3x5");
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 1'b1, 1'b0, "max");
    mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0, 1'b0, 1'b0, "msb");
    mul(32'h0000_1234, 32'd0, 64'd0, 0, 1'b0, 1'b0, "zero");
    mul(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1, 1'b0, 1'b0, "16b");
    mul(32'd7, 32'd6, 64'd42, 0, 1'b0, 1'b0, "7x6");

    abort_at(10, "abort run10");
    abort_at(32, "abort last");
    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, 1'b1, "after abort");

    @(negedge clk);
    mcand = 32'h0001_0000; mplier = 32'h0001_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; edges = 1;
    while (edges < 20) begin @(negedge clk); edges++; end
    #2 reset_n = 1'b0;
    #1;
    chk("async reset busy", {63'b0, busy}, 64'd0);
    chk("async reset valid", {63'b0, result_valid}, 64'd0);
    chk("async reset result", result, 64'd0);
    chk("async reset alu op", {58'b0, alu_s, alu_m, alu_cin_n}, 64'b111111);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mul(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0, 1'b0, 1'b0, "after reset");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
